branch_predictor: RTL and testbench
===================================

# branch_predictor

Dynamic branch predictor and resolution unit for the pipelined RV32I core. It gives fetch a taken/not-taken prediction from a table of 2-bit saturating counters. In the execute stage it consumes the branch comparator's `br_en` result, detects mispredictions, issues a registered flush/redirect, trains the table and keeps branch statistics.

## Interface
Parameters:
- `ENTRIES`, default 64: number of BHT entries; must be a power of two, ≥ 2.
- `width`, default 32: address and data width.

Ports:
- `clk` — in, 1: core clock.
- `rst` — in, 1: reset; synchronous, active-high.
- `if_pc` — in, `width`: PC of the instruction being fetched.
- `if_pred_taken` — out, 1: prediction for `if_pc`; combinational table read.
- `ex_valid` — in, 1: the EX stage holds a valid instruction.
- `ex_is_branch` — in, 1: the EX instruction is a conditional branch.
- `ex_stall` — in, 1: the pipeline is frozen this cycle.
- `ex_pc` — in, `width`: PC of the EX instruction.
- `ex_target` — in, `width`: branch target, computed as `ex_pc` + B-immediate.
- `ex_pred_taken` — in, 1: prediction carried down the pipe with this instruction.
- `ex_br_en` — in, 1: branch comparator result.
- `flush` — out, 1: squash IF/ID/EX; registered.
- `redirect_pc` — out, `width`: fetch PC to use when `flush` = 1; registered.
- `br_count` — out, 32: resolved branches.
- `mispred_count` — out, 32: mispredicted branches.

## Operation
- Index: `idx = pc[$clog2(ENTRIES)+1:2]`.
- Counter encoding: SNT=00, WNT=01, WT=10, ST=11.
- Prediction: `if_pred_taken = table[idx(if_pc)][1]`.
- Resolve event: `res = ex_valid & ex_is_branch & ~ex_stall & ~flush`.
  - The `~flush` term ensures the wrong-path instruction sitting in EX during the flush cycle is ignored entirely.
- On `res`:
  - Update `table[idx(ex_pc)]`:
    - `ex_br_en`=1: increment, saturating at 11.
    - `ex_br_en`=0: decrement, saturating at 00.
  - `br_count` increments by 1, saturating at 32'hFFFF_FFFF.
  - If `ex_br_en != ex_pred_taken`:
    - `mispred_count` increments, saturating.
    - Next cycle `flush`=1 and `redirect_pc = ex_br_en ? ex_target : ex_pc + 4`.
    - The +4 is computed modulo 2^`width`, so `ex_pc` = 32'hFFFF_FFFC gives 32'h0000_0000.
- Otherwise, next cycle `flush`=0 and `redirect_pc` holds its previous value.
- `ex_stall`=1 or `ex_valid`=0:
  - No table or counter update.
  - `flush` deasserts next cycle.
- Read/write to the same index in one cycle: the read returns the old value. There is no bypass.
- Reset state:
  - Every table entry = WNT (01).
  - `flush`=0, `redirect_pc`=0.
  - `br_count`=0, `mispred_count`=0.
  - `if_pred_taken` therefore reads 0.
- Reset asserted mid-operation overrides any pending update or flush in that same cycle.

## Timing
- Prediction latency: 0 cycles, combinational from `if_pc`.
- Resolve to `flush`/`redirect_pc`: 1 cycle. Both are registered from the `res` cycle.
- `flush` is a single-cycle pulse per misprediction. Back-to-back pulses are impossible because of the `~flush` qualification.
- Table and statistics counters update at the clock edge ending the `res` cycle. They are visible to `if_pc` reads in the following cycle.
- Statistics outputs are registered and have no read latency beyond that.

## Structure
- Add to `rv32i_types`:
  - `bht_state_t` enum with values `SNT`, `WNT`, `WT`, `ST`.
  - Constant `BHT_RESET_STATE = WNT`.
- Sub-module `sat_counter2`: pure next-state function taking a `bht_state_t` and a taken bit, returning the next `bht_state_t`. It is instantiated once, on the update path.
- The table is a flop array, not SRAM, so that all entries reset in one cycle.

## Test plan
- **Reset defaults:** assert `rst` for 1 cycle, sweep `if_pc` over 0x0–0xFC → `if_pred_taken`=0 everywhere; both counts 0; `flush`=0.
- **Training and saturation:** resolve `ex_pc`=0x40 with `ex_br_en`=1 three times → entry moves 01→10→11→11. `if_pc`=0x40 predicts 1 from the cycle after the first update.
- **Mispredict, taken:** `ex_pc`=0x100, `ex_pred_taken`=0, `ex_br_en`=1, `ex_target`=0x80 → next cycle `flush`=1 and `redirect_pc`=0x80; `mispred_count`=1.
- **Mispredict, not taken with wrap:** `ex_pc`=0xFFFF_FFFC, `ex_pred_taken`=1, `ex_br_en`=0 → `redirect_pc`=0x0000_0000 and `flush`=1.
- **Squash in the flush cycle:** a second mispredicting branch is presented in the cycle `flush`=1 → no second flush; no counter or table change.
- **Stall and mid-op reset:** a mispredicting branch with `ex_stall`=1 → no update and no flush. Then `rst` asserted together with a valid resolve → all state returns to reset values and `flush`=0.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I core types: branch history table counter encoding.
package rv32i_types;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_state_t;

    localparam bht_state_t BHT_RESET_STATE = WNT;

endpackage

// File: rtl/sat_counter2.sv
// Next-state function of a 2-bit saturating branch counter.
module sat_counter2
    import rv32i_types::*;
(
    input  bht_state_t i_state,
    input  logic       i_taken,
    output bht_state_t o_next
);

    always_comb begin
        o_next = i_state;
        unique case (i_state)
            SNT: o_next = i_taken ? WNT : SNT;
            WNT: o_next = i_taken ? WT  : SNT;
            WT:  o_next = i_taken ? ST  : WNT;
            ST:  o_next = i_taken ? ST  : WT;
            default: o_next = i_state;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// 2-bit counter branch predictor with EX-stage resolution, registered flush/redirect
// and saturating branch statistics.
module branch_predictor
    import rv32i_types::*;
#(
    parameter int unsigned ENTRIES = 64,
    parameter int unsigned width   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [width-1:0] if_pc,
    output logic             if_pred_taken,
    input  logic             ex_valid,
    input  logic             ex_is_branch,
    input  logic             ex_stall,
    input  logic [width-1:0] ex_pc,
    input  logic [width-1:0] ex_target,
    input  logic             ex_pred_taken,
    input  logic             ex_br_en,
    output logic             flush,
    output logic [width-1:0] redirect_pc,
    output logic [31:0]      br_count,
    output logic [31:0]      mispred_count
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);

    bht_state_t       r_table [ENTRIES];
    logic             r_flush;
    logic [width-1:0] r_redirect_pc;
    logic [31:0]      r_br_count;
    logic [31:0]      r_mispred_count;

    logic [IDX_W-1:0] w_if_idx;
    logic [IDX_W-1:0] w_ex_idx;
    bht_state_t       w_cur_state;
    bht_state_t       w_next_state;
    logic             w_res;
    logic             w_mispred;
    logic [width-1:0] w_redirect;
    logic             w_unused_pc_bits;

    assign w_if_idx = if_pc[IDX_W+1:2];
    assign w_ex_idx = ex_pc[IDX_W+1:2];
    assign w_unused_pc_bits = ^{if_pc[width-1:IDX_W+2], if_pc[1:0]};

    // Read returns the pre-update entry; no write bypass.
    assign if_pred_taken = r_table[w_if_idx][1];
    assign w_cur_state   = r_table[w_ex_idx];

    // The wrong-path instruction in EX during a flush cycle must not resolve.
    assign w_res      = ex_valid & ex_is_branch & ~ex_stall & ~r_flush;
    assign w_mispred  = w_res & (ex_br_en != ex_pred_taken);
    assign w_redirect = ex_br_en ? ex_target : ex_pc + width'(4);

    sat_counter2 u_sat_counter2 (
        .i_state (w_cur_state),
        .i_taken (ex_br_en),
        .o_next  (w_next_state)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_table[i] <= BHT_RESET_STATE;
            end
            r_flush         <= 1'b0;
            r_redirect_pc   <= '0;
            r_br_count      <= '0;
            r_mispred_count <= '0;
        end else begin
            r_flush <= w_mispred;
            if (w_mispred) begin
                r_redirect_pc <= w_redirect;
            end
            if (w_res) begin
                r_table[w_ex_idx] <= w_next_state;
                if (r_br_count != 32'hFFFF_FFFF) begin
                    r_br_count <= r_br_count + 32'd1;
                end
            end
            if (w_mispred && (r_mispred_count != 32'hFFFF_FFFF)) begin
                r_mispred_count <= r_mispred_count + 32'd1;
            end
        end
    end

    assign flush         = r_flush;
    assign redirect_pc   = r_redirect_pc;
    assign br_count      = r_br_count;
    assign mispred_count = r_mispred_count;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor; flush/redirect events checked via a scoreboard queue.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic        ex_valid;
    logic        ex_is_branch;
    logic        ex_stall;
    logic [31:0] ex_pc;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic        ex_br_en;
    logic        flush;
    logic [31:0] redirect_pc;
    logic [31:0] br_count;
    logic [31:0] mispred_count;

    typedef struct {
        int          cyc;
        logic [31:0] pc;
    } flush_exp_t;

    flush_exp_t sb[$];
    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    branch_predictor #(.ENTRIES(64), .width(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .if_pc         (if_pc),
        .if_pred_taken (if_pred_taken),
        .ex_valid      (ex_valid),
        .ex_is_branch  (ex_is_branch),
        .ex_stall      (ex_stall),
        .ex_pc         (ex_pc),
        .ex_target     (ex_target),
        .ex_pred_taken (ex_pred_taken),
        .ex_br_en      (ex_br_en),
        .flush         (flush),
        .redirect_pc   (redirect_pc),
        .br_count      (br_count),
        .mispred_count (mispred_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every flush pulse must match the next scoreboard entry in cycle and target.
    always @(negedge clk) begin
        if (flush === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_flush: got flush=1 redirect=0x%08h at cycle %0d expected none",
                         redirect_pc, cyc);
            end else begin
                flush_exp_t e;
                e = sb.pop_front();
                check("flush_cycle", 32'(cyc), 32'(e.cyc));
                check("redirect_pc", redirect_pc, e.pc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ex_valid      = 1'b0;
        ex_is_branch  = 1'b0;
        ex_stall      = 1'b0;
        ex_pred_taken = 1'b0;
        ex_br_en      = 1'b0;
    endtask

    // Drive one branch into EX for the coming edge; push the expected flush if it mispredicts.
    task automatic drive_br(input logic [31:0] pc, input logic [31:0] tgt, input logic pred,
                            input logic taken, input logic stall, input logic exp_flush,
                            input logic [31:0] exp_redir);
        flush_exp_t e;
        ex_valid      = 1'b1;
        ex_is_branch  = 1'b1;
        ex_stall      = stall;
        ex_pc         = pc;
        ex_target     = tgt;
        ex_pred_taken = pred;
        ex_br_en      = taken;
        if (exp_flush) begin
            e.cyc = cyc + 1;
            e.pc  = exp_redir;
            sb.push_back(e);
        end
    endtask

    task automatic sweep_zero(input string name);
        int bad = 0;
        for (int i = 0; i < 64; i++) begin
            if_pc = 32'(i * 4);
            #1;
            if (if_pred_taken !== 1'b0) bad++;
        end
        check(name, 32'(bad), 32'd0);
    endtask

    task automatic pred_at(input string name, input logic [31:0] pc, input logic exp);
        if_pc = pc;
        #1;
        check(name, {31'd0, if_pred_taken}, {31'd0, exp});
    endtask

    initial begin
        idle();
        ex_pc     = '0;
        ex_target = '0;
        if_pc     = '0;
        rst       = 1'b1;
        tick();
        rst = 1'b0;

        // Reset defaults
        sweep_zero("reset_pred_sweep");
        check("reset_br_count", br_count, 32'd0);
        check("reset_mispred_count", mispred_count, 32'd0);
        check("reset_flush", {31'd0, flush}, 32'd0);
        check("reset_redirect", redirect_pc, 32'd0);

        // Training 0x40: 01 -> 10 -> 11 -> 11, correctly predicted
        if_pc = 32'h40;
        drive_br(32'h40, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        #1;
        check("pred_old_during_write", {31'd0, if_pred_taken}, 32'd0);
        tick();
        pred_at("pred_after_first_train", 32'h40, 1'b1);
        drive_br(32'h40, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        drive_br(32'h40, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        // Not-taken from ST: 11 -> 10, still predicts taken; mispredict -> pc+4
        drive_br(32'h40, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h44);
        tick();
        idle();
        pred_at("pred_after_sat_dec1", 32'h40, 1'b1);
        tick();
        drive_br(32'h40, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h44);
        tick();
        idle();
        pred_at("pred_after_sat_dec2", 32'h40, 1'b0);
        check("train_br_count", br_count, 32'd5);
        check("train_mispred_count", mispred_count, 32'd2);
        tick();

        // Mispredict taken: redirect to target
        drive_br(32'h100, 32'h80, 1'b0, 1'b1, 1'b0, 1'b1, 32'h80);
        tick();
        idle();
        check("mt_mispred_count", mispred_count, 32'd3);
        check("mt_br_count", br_count, 32'd6);
        pred_at("mt_entry0_trained", 32'h0, 1'b1);
        tick();

        // Mispredict not-taken with PC wrap; then squashed branch in the flush cycle
        drive_br(32'hFFFF_FFFC, 32'h1234, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
        tick();
        check("wrap_flush_high", {31'd0, flush}, 32'd1);
        drive_br(32'h208, 32'h300, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        idle();
        check("squash_no_flush", {31'd0, flush}, 32'd0);
        check("squash_br_count", br_count, 32'd7);
        check("squash_mispred_count", mispred_count, 32'd4);
        pred_at("squash_no_table_change", 32'h208, 1'b0);
        pred_at("wrap_entry63_dec", 32'hFC, 1'b0);
        tick();

        // Stalled mispredicting branch: no effect at all
        drive_br(32'h20C, 32'h400, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        idle();
        check("stall_no_flush", {31'd0, flush}, 32'd0);
        check("stall_br_count", br_count, 32'd7);
        check("stall_mispred_count", mispred_count, 32'd4);
        pred_at("stall_no_table_change", 32'h20C, 1'b0);
        check("stall_redirect_held", redirect_pc, 32'h0);
        tick();

        // Reset together with a mispredicting resolve: reset wins
        rst = 1'b1;
        drive_br(32'h0, 32'h500, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        rst = 1'b0;
        idle();
        check("midrst_flush", {31'd0, flush}, 32'd0);
        check("midrst_br_count", br_count, 32'd0);
        check("midrst_mispred_count", mispred_count, 32'd0);
        check("midrst_redirect", redirect_pc, 32'd0);
        sweep_zero("midrst_pred_sweep");
        tick();
        tick();

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
